keystream_gen: RTL and testbench

Keystream generator that sits directly upstream of the `xorer` stage and supplies its 32-bit `key` word. It holds a xorshift32 state seeded by the controller and presents one fresh key word per accepted transfer over a valid/ready handshake. Its output drives `key` of the XOR stage, and `key_valid` qualifies that stage's `enabled`. It also counts words delivered since the last seed and flags when a rekey interval is reached.

---
 rtl/keystream_pkg.sv | 25 ++
 rtl/xorshift32_step.sv | 10 +
 rtl/keystream_gen.sv | 129 ++++++++++++
 tb/tb_keystream_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keystream_pkg.sv
// Shared types, constants and the xorshift32 step function
// for the keystream generator.
package keystream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } ks_state_e;

    localparam int unsigned SH_A = 13;
    localparam int unsigned SH_B = 17;
    localparam int unsigned SH_C = 5;

    localparam logic [31:0] ZERO_SEED_SUB = 32'h0000_0001;

    function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << SH_A);
        t = t ^ (t >> SH_B);
        t = t ^ (t << SH_C);
        return t;
    endfunction

endpackage

// File: rtl/xorshift32_step.sv
// Combinational single xorshift32 step, shared between the
// priming and running paths of the generator.
module xorshift32_step (
    input  logic [31:0] x_i,
    output logic [31:0] x_o
);

    assign x_o = keystream_pkg::xorshift32_step(x_i);

endmodule

// File: rtl/keystream_gen.sv
// Seeded xorshift32 keystream source with valid/ready output,
// delivered-word counter and rekey pulse.
module keystream_gen
    import keystream_pkg::*;
#(
    parameter int unsigned REKEY_INTERVAL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_valid,
    input  logic [31:0] seed,
    output logic        seed_ready,
    output logic        key_valid,
    input  logic        key_ready,
    output logic [31:0] key,
    output logic        seed_err,
    output logic [31:0] word_count,
    output logic        rekey_req
);

    localparam logic [31:0] REKEY_AT = 32'(REKEY_INTERVAL);

    ks_state_e   state_q, state_d;
    logic [31:0] xs_q, xs_d;
    logic [31:0] key_q, key_d;
    logic        key_valid_q, key_valid_d;
    logic [31:0] cnt_q, cnt_d;
    logic        seed_err_q, seed_err_d;
    logic        rekey_q, rekey_d;

    logic        seed_hs;
    logic        key_hs;
    logic        cnt_max;
    logic [31:0] step_in;
    logic [31:0] step_out;

    // Ready is a pure state decode so it never loops back through key_ready.
    assign seed_ready = (state_q == IDLE) || (state_q == RUN);
    assign seed_hs    = seed_valid & seed_ready;
    assign key_hs     = key_valid_q & key_ready;
    assign cnt_max    = (cnt_q == 32'hFFFF_FFFF);
    assign step_in    = (state_q == PRIME) ? xs_q : key_q;

    xorshift32_step u_step (
        .x_i (step_in),
        .x_o (step_out)
    );

    always_comb begin
        state_d     = state_q;
        xs_d        = xs_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        cnt_d       = cnt_q;
        seed_err_d  = 1'b0;
        rekey_d     = 1'b0;

        if (key_hs && !cnt_max) begin
            cnt_d = cnt_q + 32'd1;
            if (REKEY_AT != 32'd0 && (cnt_q + 32'd1) == REKEY_AT) begin
                rekey_d = 1'b1;
            end
        end

        // A seed clears the count even when a transfer lands the same cycle.
        if (seed_hs) begin
            cnt_d = 32'd0;
            if (seed == 32'd0) begin
                xs_d       = ZERO_SEED_SUB;
                seed_err_d = 1'b1;
            end else begin
                xs_d = seed;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (seed_hs) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                key_d       = step_out;
                key_valid_d = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                if (key_hs) begin
                    key_d = step_out;
                end
                if (seed_hs) begin
                    key_valid_d = 1'b0;
                    state_d     = PRIME;
                end
            end
            default: begin
                state_d     = IDLE;
                key_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            xs_q        <= 32'd0;
            key_q       <= 32'd0;
            key_valid_q <= 1'b0;
            cnt_q       <= 32'd0;
            seed_err_q  <= 1'b0;
            rekey_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            xs_q        <= xs_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            cnt_q       <= cnt_d;
            seed_err_q  <= seed_err_d;
            rekey_q     <= rekey_d;
        end
    end

    assign key        = key_q;
    assign key_valid  = key_valid_q;
    assign word_count = cnt_q;
    assign seed_err   = seed_err_q;
    assign rekey_req  = rekey_q;

endmodule

// File: tb/tb_keystream_gen.sv
// Scoreboard bench for keystream_gen: directed plan items plus
// randomized seeding/backpressure against a cycle-level reference.
module tb_keystream_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_valid;
    logic [31:0] seed;
    logic        seed_ready;
    logic        key_valid;
    logic        key_ready;
    logic [31:0] key;
    logic        seed_err;
    logic [31:0] word_count;
    logic        rekey_req;

    always #5 clk = ~clk;

    keystream_gen #(.REKEY_INTERVAL(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed       (seed),
        .seed_ready (seed_ready),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .seed_err   (seed_err),
        .word_count (word_count),
        .rekey_req  (rekey_req)
    );

    typedef struct {
        logic [31:0] k;
        logic [31:0] c;
    } xfer_t;

    xfer_t xq[$];
    int    errq[$];
    int    rkq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // reference model: 0 = no seed yet, 1 = priming, 2 = delivering
    int          phase;
    logic [31:0] st_m;
    logic [31:0] key_m;
    logic [31:0] cnt_m;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        phase = 0;
        st_m  = 32'd0;
        key_m = 32'd0;
        cnt_m = 32'd0;
        xq.delete();
        errq.delete();
        rkq.delete();
    endtask

    // drive one cycle and advance the reference for the closing edge
    task automatic step(input logic kr, input logic sv, input logic [31:0] sd);
        @(posedge clk);
        #1;
        key_ready  = kr;
        seed_valid = sv;
        seed       = sd;
        if (phase == 2 && kr) begin
            xq.push_back('{k: key_m, c: cnt_m});
            key_m = xs(key_m);
            if (cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
            if (cnt_m == 32'd4) rkq.push_back(cyc + 1);
        end
        if (sv && phase != 1) begin
            st_m  = (sd == 32'd0) ? 32'd1 : sd;
            if (sd == 32'd0) errq.push_back(cyc + 1);
            cnt_m = 32'd0;
            phase = 1;
        end else if (phase == 1) begin
            key_m = xs(st_m);
            phase = 2;
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT shows a transfer or pulse
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (key_valid && key_ready) begin
                    if (xq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL xfer: unexpected key %h", key);
                    end else begin
                        xfer_t e;
                        e = xq.pop_front();
                        chk("xfer_key", key, e.k);
                        chk("xfer_count", word_count, e.c);
                    end
                end
                if (errq.size() > 0 && errq[0] < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL seed_err: got 0 expected 1 at cycle %0d", errq[0]);
                    void'(errq.pop_front());
                end
                if (seed_err) begin
                    checks++;
                    if (errq.size() > 0 && errq[0] == cyc) begin
                        void'(errq.pop_front());
                    end else begin
                        errors++;
                        $display("FAIL seed_err: got 1 expected 0 at cycle %0d", cyc);
                    end
                end
                if (rkq.size() > 0 && rkq[0] < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL rekey_req: got 0 expected 1 at cycle %0d", rkq[0]);
                    void'(rkq.pop_front());
                end
                if (rekey_req) begin
                    checks++;
                    if (rkq.size() > 0 && rkq[0] == cyc) begin
                        void'(rkq.pop_front());
                    end else begin
                        errors++;
                        $display("FAIL rekey_req: got 1 expected 0 at cycle %0d", cyc);
                    end
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        seed_valid = 1'b0;
        seed       = 32'd0;
        key_ready  = 1'b0;
        model_reset();

        #12;
        chk("rst_key", key, 32'd0);
        chk("rst_key_valid", 32'(key_valid), 32'd0);
        chk("rst_word_count", word_count, 32'd0);
        chk("rst_seed_err", 32'(seed_err), 32'd0);
        chk("rst_rekey", 32'(rekey_req), 32'd0);
        chk("rst_seed_ready", 32'(seed_ready), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // seed=1 with continuous ready
        step(1'b1, 1'b1, 32'd1);
        step(1'b1, 1'b0, 32'd0);
        chk("prime_valid", 32'(key_valid), 32'd0);
        chk("prime_seed_ready", 32'(seed_ready), 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk("first_key", key, 32'h0004_2021);
        chk("first_valid", 32'(key_valid), 32'd1);
        step(1'b1, 1'b0, 32'd0);
        chk("second_key", key, 32'h0408_0601);
        chk("run_seed_ready", 32'(seed_ready), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0);

        // reseed together with a transfer
        step(1'b1, 1'b1, 32'd1);
        step(1'b1, 1'b0, 32'd0);
        chk("reseed_valid", 32'(key_valid), 32'd0);
        chk("reseed_count", word_count, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk("reseed_key", key, 32'h0004_2021);

        // zero seed then stall
        step(1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'd0);
            chk("stall_key", key, 32'h0004_2021);
            chk("stall_count", word_count, 32'd0);
        end
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        chk("release_key", key, 32'h0408_0601);
        chk("release_count", word_count, 32'd1);

        // randomized seeding and backpressure
        for (int i = 0; i < 400; i++) begin
            logic        kr;
            logic        sv;
            logic [31:0] sd;
            kr = ($urandom_range(0, 3) != 0);
            sv = ($urandom_range(0, 15) == 0);
            sd = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            step(kr, sv, sd);
        end

        // asynchronous reset mid-stream
        step(1'b1, 1'b1, 32'h1234_5678);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_key", key, 32'd0);
        chk("async_valid", 32'(key_valid), 32'd0);
        chk("async_count", word_count, 32'd0);
        chk("async_seed_ready", 32'(seed_ready), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'd0);
            chk("post_rst_valid", 32'(key_valid), 32'd0);
        end
        step(1'b1, 1'b1, 32'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0);

        chk("drain_xfer", 32'(xq.size()), 32'd0);
        chk("drain_seed_err", 32'(errq.size()), 32'd0);
        chk("drain_rekey", 32'(rkq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
